pipe_alu_par: RTL and testbench

Parametrised three-stage pipelined ALU with valid/ready flow control. Each stage is a register: decode, execute, parity. An operation is a one-hot function byte plus two WIDTH-bit operands. The pipeline produces the result, a carry/borrow flag, an invalid-function flag and a parity bit. It sits between an operand/command source and any downstream consumer that can apply backpressure. One result is accepted and delivered per cycle when nothing stalls.

---
 rtl/pipe_alu_par.sv | 124 ++++++++++++
 tb/tb_pipe_alu_par.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_alu_par.sv
// Three-stage pipelined ALU: decode -> execute -> parity, with valid/ready flow
// control and a combinational ready chain (no skid buffers).
module pipe_alu_par #(
  parameter int WIDTH      = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_func,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data,
  output logic             out_carry,
  output logic             out_err
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_NOT = 3'd5, OP_SHL = 3'd6, OP_SHR = 3'd7
  } op_e;

  // Stage registers
  logic             v1, v2, v3;
  op_e              op1;
  logic             err1, err2;
  logic [WIDTH-1:0] a1, b1, res2;
  logic             carry2;

  logic             rdy1, rdy2, rdy3;
  op_e              dec_op;
  logic [WIDTH-1:0] ex_res;
  logic             ex_carry;
  logic [WIDTH:0]   sum, diff;

  // A stage may load when it is empty or its successor is loading this edge.
  assign rdy3      = !v3 | out_ready;
  assign rdy2      = !v2 | rdy3;
  assign rdy1      = !v1 | rdy2;
  assign in_ready  = rdy1;
  assign out_valid = v3;

  // Priority encoder: scanning downward leaves the lowest set bit as winner.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dec_op = OP_ADD;
    for (int i = 7; i >= 0; i--) begin
      if (in_func[i]) dec_op = op_e'(3'(i));
    end
  end

  assign sum  = {1'b0, a1} + {1'b0, b1};
  assign diff = {1'b0, a1} - {1'b0, b1};

  always_comb begin
    ex_res   = '0;
    ex_carry = 1'b0;
    if (!err1) begin
      case (op1)
        OP_ADD: begin ex_res = sum[WIDTH-1:0];  ex_carry = sum[WIDTH];  end
        OP_SUB: begin ex_res = diff[WIDTH-1:0]; ex_carry = diff[WIDTH]; end
        OP_AND: ex_res = a1 & b1;
        OP_OR:  ex_res = a1 | b1;
        OP_XOR: ex_res = a1 ^ b1;
        OP_NOT: ex_res = ~a1;
        OP_SHL: begin ex_res = {a1[WIDTH-2:0], 1'b0}; ex_carry = a1[WIDTH-1]; end
        OP_SHR: begin ex_res = {1'b0, a1[WIDTH-1:1]}; ex_carry = a1[0];       end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every stage
  // samples its predecessor's pre-edge value and the pipeline shifts cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload registers are reset too, since out_data/out_carry/out_err
      // must read 0 during reset; nothing here is a RAM, so this costs nothing odd.
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      op1       <= OP_ADD;
      err1      <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      res2      <= '0;
      carry2    <= 1'b0;
      err2      <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (rdy1) begin
        v1 <= in_valid;
        if (in_valid) begin
          op1  <= dec_op;
          err1 <= (in_func == 8'h00);
          a1   <= in_a;
          b1   <= in_b;
        end
      end
      if (rdy2) begin
        v2 <= v1;
        if (v1) begin
          res2   <= ex_res;
          carry2 <= ex_carry;
          err2   <= err1;
        end
      end
      if (rdy3) begin
        v3 <= v2;
        if (v2) begin
          out_data  <= {(^res2) ^ PARITY_ODD, res2};
          out_carry <= carry2;
          out_err   <= err2;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_alu_par.sv
// Scoreboard bench for pipe_alu_par: the driver pushes hand-computed results on
// acceptance, an independent monitor pops and compares on every output transfer.
`timescale 1ns/1ps
module tb_pipe_alu_par;

  typedef struct {
    logic [7:0] f;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] d;
    logic       c;
    logic       e;
  } vec_t;

  typedef struct {
    logic [4:0] d;
    logic       c;
    logic       e;
    int         acc;
    bit         timed;
  } exp_t;

  // Hand-computed expectations for WIDTH=4, even parity.
  vec_t vt [0:13] = '{
    '{8'h01, 4'h8, 4'h7, 5'h0F, 1'b0, 1'b0},  // ADD 8+7
    '{8'h01, 4'h9, 4'h8, 5'h11, 1'b1, 1'b0},  // ADD 9+8
    '{8'h02, 4'h3, 4'h5, 5'h1E, 1'b1, 1'b0},  // SUB 3-5
    '{8'h06, 4'h3, 4'h5, 5'h1E, 1'b1, 1'b0},  // priority -> SUB
    '{8'h00, 4'hF, 4'hF, 5'h00, 1'b0, 1'b1},  // no function
    '{8'h40, 4'h9, 4'h0, 5'h12, 1'b1, 1'b0},  // SHL 1001
    '{8'h01, 4'hC, 4'hA, 5'h06, 1'b1, 1'b0},  // ADD
    '{8'h02, 4'hC, 4'hA, 5'h12, 1'b0, 1'b0},  // SUB
    '{8'h04, 4'hC, 4'hA, 5'h18, 1'b0, 1'b0},  // AND
    '{8'h08, 4'hC, 4'hA, 5'h1E, 1'b0, 1'b0},  // OR
    '{8'h10, 4'hC, 4'hA, 5'h06, 1'b0, 1'b0},  // XOR
    '{8'h20, 4'hC, 4'hA, 5'h03, 1'b0, 1'b0},  // NOT
    '{8'h40, 4'hC, 4'hA, 5'h18, 1'b1, 1'b0},  // SHL
    '{8'h80, 4'hC, 4'hA, 5'h06, 1'b0, 1'b0}   // SHR
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_func = '0;
  logic [3:0] in_a = '0, in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] out_data;
  logic       out_carry, out_err;

  logic       w8_in_valid = 1'b0;
  logic       w8_in_ready;
  logic [7:0] w8_func = '0, w8_a = '0, w8_b = '0;
  logic       w8_out_valid;
  logic       w8_out_ready = 1'b1;
  logic [8:0] w8_data;
  logic       w8_carry, w8_err;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  bit   timed_mode = 1'b1;
  bit   push_en = 1'b1;
  exp_t exp_q[$];

  pipe_alu_par #(.WIDTH(4), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_carry(out_carry),
    .out_err(out_err)
  );

  pipe_alu_par #(.WIDTH(8), .PARITY_ODD(1'b1)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
    .in_func(w8_func), .in_a(w8_a), .in_b(w8_b), .out_valid(w8_out_valid),
    .out_ready(w8_out_ready), .out_data(w8_data), .out_carry(w8_carry),
    .out_err(w8_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Present vector i until accepted; the expectation is queued on acceptance.
  task automatic send(input int i);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_func  = vt[i].f;
    in_a     = vt[i].a;
    in_b     = vt[i].b;
    #2;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      acc_cnt++;
      if (push_en) exp_q.push_back('{vt[i].d, vt[i].c, vt[i].e, cyc + 1, timed_mode});
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic w8_op(input string nm, input logic [7:0] f, input logic [7:0] a,
                       input logic [7:0] b, input logic [8:0] ed, input logic ec);
    int n = 0;
    @(negedge clk);
    w8_in_valid = 1'b1;
    w8_func = f;
    w8_a = a;
    w8_b = b;
    #1;
    check({nm, "_in_ready"}, w8_in_ready, 1'b1);
    @(posedge clk);
    #1;
    w8_in_valid = 1'b0;
    @(negedge clk);
    while (!w8_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_valid"}, w8_out_valid, 1'b1);
    check({nm, "_data"}, w8_data, ed);
    check({nm, "_carry"}, w8_carry, ec);
    check({nm, "_err"}, w8_err, 1'b0);
  endtask

  // Monitor: compares every output transfer against the queue head and
  // verifies the payload is held while the consumer stalls.
  initial begin : monitor
    bit         stall_prev = 1'b0;
    logic [6:0] held = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_payload", {out_err, out_carry, out_data}, held);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", {out_err, out_carry, out_data}, 32'hDEAD);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.d);
            check("out_carry", out_carry, e.c);
            check("out_err", out_err, e.e);
            if (e.timed) check("latency", cyc, e.acc + 2);
          end
        end
        stall_prev = out_valid && !out_ready;
        held = {out_err, out_carry, out_data};
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit done;
    int base;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic, priority and error cases, then 8 back-to-back ops.
    for (int i = 0; i < 14; i++) send(i);
    drain();

    // Reset with two ops in flight: they must vanish without a trace.
    push_en = 1'b0;
    send(6);
    send(7);
    push_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_payload", {out_err, out_carry, out_data}, 32'd0);
    check("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_no_stale", out_valid, 1'b0);

    // Backpressure: exactly three ops absorbed, then release.
    timed_mode = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    base = acc_cnt;
    fork
      for (int i = 6; i < 11; i++) send(i);
      begin
        repeat (5) @(negedge clk);
        #1;
        check("stall_absorbed", acc_cnt - base, 32'd3);
        check("stall_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1'b1);
      end
    join
    drain();

    // Random consumer stalls and producer bubbles over the whole table.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 14; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send(i);
        end
        done = 1'b1;
      end
      while (!done) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1'b1;
    drain();

    // WIDTH=8, odd parity instance.
    w8_op("w8_add", 8'h01, 8'hFF, 8'h01, 9'h100, 1'b1);
    w8_op("w8_shr", 8'h80, 8'h81, 8'h00, 9'h040, 1'b1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
